placement_ctrl: RTL and testbench

//  Upstream control stage for game_board. Converts raw mouse pixel position and left-click

---
 rtl/placement_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_placement_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/placement_ctrl.sv
// Front-end control for game_board: turns mouse pixels and clicks into cell coordinates,
// place/shot strobes and the host -> guest -> battle phase code.
module placement_ctrl #(
    parameter int X0    = 64,
    parameter int Y0    = 64,
    parameter int CELL  = 48,
    parameter int GRID  = 10,
    parameter int SHIPS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        start_btn,
    input  logic        game_over,
    output logic [1:0]  start,
    output logic        place,
    output logic [5:0]  mouse_pos,
    output logic [6:0]  cell_idx,
    output logic [2:0]  ships_left
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOST   = 3'd1,
        S_GUEST  = 3'd2,
        S_BATTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [11:0] X_END = 12'(X0 + GRID * CELL);
    localparam logic [11:0] Y_END = 12'(Y0 + GRID * CELL);

    state_t      state_q, state_d;
    logic [2:0]  ml_q, ml_d;
    logic [2:0]  sb_q, sb_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic [1:0]  start_q, start_d;
    logic        place_q, place_d;
    logic [5:0]  mouse_pos_q, mouse_pos_d;
    logic [6:0]  cell_idx_q, cell_idx_d;
    logic [2:0]  ships_left_q, ships_left_d;
    logic [63:0] occ_host_q, occ_host_d;
    logic [63:0] occ_guest_q, occ_guest_d;

    logic [3:0]  col_s, row_s;
    logic        on_grid_s, click_s, start_edge_s, accept_s;
    logic [5:0]  occ_idx_s;

    // Cell decode: count crossed cell boundaries instead of dividing.
    always_comb begin
        col_s = 4'd0;
        row_s = 4'd0;
        for (int k = 1; k < GRID; k++) begin
            if (x_q >= 12'(X0 + k * CELL)) begin
                col_s = col_s + 4'd1;
            end else begin
                col_s = col_s;
            end
            if (y_q >= 12'(Y0 + k * CELL)) begin
                row_s = row_s + 4'd1;
            end else begin
                row_s = row_s;
            end
        end
        on_grid_s = (x_q >= 12'(X0)) && (y_q >= 12'(Y0)) && (x_q < X_END) && (y_q < Y_END);
        click_s      = ml_q[1] & ~ml_q[2];
        start_edge_s = sb_q[1] & ~sb_q[2];
        // Consumer coordinates are 3-bit, so rows/cols 8 and 9 cannot be addressed.
        accept_s  = click_s && on_grid_s && (row_s < 4'd8) && (col_s < 4'd8);
        occ_idx_s = {row_s[2:0], col_s[2:0]};
    end

    // Next-state, phase sequencing and output computation.
    always_comb begin
        ml_d         = {ml_q[1:0], mouse_left};
        sb_d         = {sb_q[1:0], start_btn};
        x_d          = mouse_xpos;
        y_d          = mouse_ypos;
        state_d      = state_q;
        place_d      = 1'b0;
        mouse_pos_d  = mouse_pos_q;
        ships_left_d = ships_left_q;
        occ_host_d   = occ_host_q;
        occ_guest_d  = occ_guest_q;
        if (on_grid_s) begin
            cell_idx_d = 7'(row_s) * 7'(GRID) + 7'(col_s);
        end else begin
            cell_idx_d = 7'd127;
        end
        case (state_q)
            S_IDLE, S_DONE: begin
                ships_left_d = 3'(SHIPS);
                if (start_edge_s) begin
                    state_d     = S_HOST;
                    occ_host_d  = 64'd0;
                    occ_guest_d = 64'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_HOST: begin
                if (accept_s && !occ_host_q[occ_idx_s]) begin
                    place_d                = 1'b1;
                    mouse_pos_d            = occ_idx_s;
                    occ_host_d[occ_idx_s]  = 1'b1;
                    if (ships_left_q == 3'd1) begin
                        state_d      = S_GUEST;
                        ships_left_d = 3'(SHIPS);
                    end else begin
                        ships_left_d = ships_left_q - 3'd1;
                    end
                end else begin
                    place_d = 1'b0;
                end
            end
            S_GUEST: begin
                if (accept_s && !occ_guest_q[occ_idx_s]) begin
                    place_d                = 1'b1;
                    mouse_pos_d            = occ_idx_s;
                    occ_guest_d[occ_idx_s] = 1'b1;
                    if (ships_left_q == 3'd1) begin
                        state_d      = S_BATTLE;
                        ships_left_d = 3'(SHIPS);
                    end else begin
                        ships_left_d = ships_left_q - 3'd1;
                    end
                end else begin
                    place_d = 1'b0;
                end
            end
            S_BATTLE: begin
                if (game_over) begin
                    state_d = S_DONE;
                end else if (accept_s) begin
                    place_d     = 1'b1;
                    mouse_pos_d = occ_idx_s;
                end else begin
                    place_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Phase code lags the state by one cycle so a phase-completing strobe keeps its code.
        case (state_q)
            S_HOST:   start_d = 2'b01;
            S_GUEST:  start_d = 2'b10;
            S_BATTLE: start_d = 2'b00;
            default:  start_d = 2'b11;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ml_q         <= 3'd0;
            sb_q         <= 3'd0;
            x_q          <= 12'd0;
            y_q          <= 12'd0;
            start_q      <= 2'b11;
            place_q      <= 1'b0;
            mouse_pos_q  <= 6'd0;
            cell_idx_q   <= 7'd127;
            ships_left_q <= 3'(SHIPS);
            occ_host_q   <= 64'd0;
            occ_guest_q  <= 64'd0;
        end else begin
            state_q      <= state_d;
            ml_q         <= ml_d;
            sb_q         <= sb_d;
            x_q          <= x_d;
            y_q          <= y_d;
            start_q      <= start_d;
            place_q      <= place_d;
            mouse_pos_q  <= mouse_pos_d;
            cell_idx_q   <= cell_idx_d;
            ships_left_q <= ships_left_d;
            occ_host_q   <= occ_host_d;
            occ_guest_q  <= occ_guest_d;
        end
    end

    assign start      = start_q;
    assign place      = place_q;
    assign mouse_pos  = mouse_pos_q;
    assign cell_idx   = cell_idx_q;
    assign ships_left = ships_left_q;

endmodule

// File: tb/tb_placement_ctrl.sv
// Directed bench for placement_ctrl: a game-level reference model checked every cycle,
// plus literal expectations on key points of the game flow.
module tb_placement_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mouse_xpos = 12'd0;
    logic [11:0] mouse_ypos = 12'd0;
    logic        mouse_left = 1'b0;
    logic        start_btn  = 1'b0;
    logic        game_over  = 1'b0;
    logic [1:0]  start;
    logic        place;
    logic [5:0]  mouse_pos;
    logic [6:0]  cell_idx;
    logic [2:0]  ships_left;

    int total = 0;
    int bad   = 0;
    int n_host = 0, n_guest = 0, n_battle = 0, n_place = 0;

    placement_ctrl dut (
        .clk(clk), .rst(rst), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .mouse_left(mouse_left), .start_btn(start_btn), .game_over(game_over),
        .start(start), .place(place), .mouse_pos(mouse_pos), .cell_idx(cell_idx),
        .ships_left(ships_left)
    );

    always #5 clk = ~clk;

    // Reference model: game phases, per-player occupied cells, input sample history.
    int          m_phase;  // 0 idle, 1 host, 2 guest, 3 battle, 4 done
    int          m_left;
    bit [63:0]   m_occ_h, m_occ_g;
    bit [3:0]    h_ml, h_st;
    int          hx0, hy0, hx1, hy1;
    int          e_start, e_place, e_pos, e_cell, e_left;

    function automatic int code_of(input int ph);
        case (ph)
            1: return 2;
            2: return 1;
            3: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int code_bits(input int ph);
        // start encoding: host 01, guest 10, battle 00, idle/done 11
        case (ph)
            1: return 1;
            2: return 2;
            3: return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int cell_of(input int x, input int y);
        if (x < 64 || y < 64 || x >= 544 || y >= 544) return 127;
        return ((y - 64) / 48) * 10 + (x - 64) / 48;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_left = 4; m_occ_h = '0; m_occ_g = '0;
        h_ml = '0; h_st = '0; hx0 = 0; hy0 = 0; hx1 = 0; hy1 = 0;
        e_start = 3; e_place = 0; e_pos = 0; e_cell = 127; e_left = 4;
    endtask

    task automatic model_step();
        int r, c, idx;
        bit clk_ev, sedge, ok;
        h_ml = {h_ml[2:0], mouse_left};
        h_st = {h_st[2:0], start_btn};
        hx1 = hx0; hy1 = hy0; hx0 = int'(mouse_xpos); hy0 = int'(mouse_ypos);
        e_start = code_bits(m_phase);
        e_cell  = cell_of(hx1, hy1);
        e_place = 0;
        clk_ev = h_ml[2] && !h_ml[3];
        sedge  = h_st[2] && !h_st[3];
        ok = 1'b0; idx = 0;
        if (e_cell != 127) begin
            r = (hy1 - 64) / 48; c = (hx1 - 64) / 48;
            ok = clk_ev && r < 8 && c < 8;
            idx = r * 8 + c;
        end
        case (m_phase)
            0, 4: begin
                m_left = 4;
                if (sedge) begin m_phase = 1; m_occ_h = '0; m_occ_g = '0; end
            end
            1, 2: begin
                if (ok && !(m_phase == 1 ? m_occ_h[idx] : m_occ_g[idx])) begin
                    e_place = 1; e_pos = idx;
                    if (m_phase == 1) m_occ_h[idx] = 1'b1; else m_occ_g[idx] = 1'b1;
                    m_left--;
                    if (m_left == 0) begin m_left = 4; m_phase++; end
                end
            end
            3: begin
                if (game_over) m_phase = 4;
                else if (ok) begin e_place = 1; e_pos = idx; end
            end
            default: m_phase = 0;
        endcase
        e_left = m_left;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus strobe bookkeeping by phase code.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("start", 32'(start), 32'(e_start));
                chk("place", 32'(place), 32'(e_place));
                chk("mouse_pos", 32'(mouse_pos), 32'(e_pos));
                chk("cell_idx", 32'(cell_idx), 32'(e_cell));
                chk("ships_left", 32'(ships_left), 32'(e_left));
                if (place === 1'b1) begin
                    n_place++;
                    if (start == 2'b01) n_host++;
                    else if (start == 2'b10) n_guest++;
                    else if (start == 2'b00) n_battle++;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        start_btn = 1'b1; cyc(3); start_btn = 1'b0; cyc(3);
    endtask

    task automatic click_px(input int x, input int y, input int hold);
        mouse_xpos = 12'(x); mouse_ypos = 12'(y); cyc(2);
        mouse_left = 1'b1; cyc(hold); mouse_left = 1'b0; cyc(4);
    endtask

    task automatic click_rc(input int r, input int c);
        click_px(64 + 48 * c + 5, 64 + 48 * r + 5, 6);
    endtask

    int p0;

    initial begin
        void'(code_of(0));
        cyc(3);
        rst = 1'b0;
        cyc(2);
        chk("reset_start", 32'(start), 32'd3);
        chk("reset_cell", 32'(cell_idx), 32'd127);
        chk("reset_left", 32'(ships_left), 32'd4);

        // Test 1: new game
        press_start();
        chk("t1_start_host", 32'(start), 32'd1);
        chk("t1_left", 32'(ships_left), 32'd4);

        // Test 2: single click held for 100 cycles
        p0 = n_place;
        click_px(64 + 48 * 2 + 5, 64 + 48 * 3 + 5, 100);
        chk("t2_one_strobe", 32'(n_place - p0), 32'd1);
        chk("t2_mouse_pos", 32'(mouse_pos), 32'b011_010);
        chk("t2_left", 32'(ships_left), 32'd3);
        chk("t2_cell_idx", 32'(cell_idx), 32'd32);

        // Test 3: duplicate, off-grid left, column 9
        p0 = n_place;
        click_rc(3, 2);
        click_px(40, 64 + 5, 6);
        click_rc(0, 9);
        chk("t3_no_strobe", 32'(n_place - p0), 32'd0);
        chk("t3_left", 32'(ships_left), 32'd3);
        mouse_xpos = 12'd40; cyc(3);
        chk("t3_offgrid_idx", 32'(cell_idx), 32'd127);
        mouse_xpos = 12'd544; mouse_ypos = 12'd100; cyc(3);
        chk("t3_right_edge_idx", 32'(cell_idx), 32'd127);

        // Test 4: finish host, then guest (overlap with host cells is allowed)
        click_rc(0, 0);
        click_rc(1, 1);
        click_rc(7, 7);
        chk("t4_guest_phase", 32'(start), 32'd2);
        chk("t4_left_reload", 32'(ships_left), 32'd4);
        click_rc(3, 2);
        click_rc(0, 0);
        click_rc(5, 6);
        click_px(447, 447, 6);
        chk("t4_last_pos", 32'(mouse_pos), 32'b111_111);
        chk("t4_battle", 32'(start), 32'd0);
        chk("t4_host_strobes", 32'(n_host), 32'd4);
        chk("t4_guest_strobes", 32'(n_guest), 32'd4);

        // Test 5: battle repeats, game over, restart
        click_rc(4, 4);
        click_rc(4, 4);
        chk("t5_battle_strobes", 32'(n_battle), 32'd2);
        game_over = 1'b1; cyc(1); game_over = 1'b0; cyc(2);
        chk("t5_done", 32'(start), 32'd3);
        p0 = n_place;
        click_rc(2, 2);
        chk("t5_done_no_strobe", 32'(n_place - p0), 32'd0);
        press_start();
        chk("t5_restart", 32'(start), 32'd1);
        chk("t5_restart_left", 32'(ships_left), 32'd4);

        // Test 6: asynchronous reset mid guest placement
        click_rc(0, 1); click_rc(0, 2); click_rc(0, 3); click_rc(0, 4);
        click_rc(6, 1); click_rc(6, 2);
        chk("t6_guest_left", 32'(ships_left), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_start", 32'(start), 32'd3);
        chk("t6_rst_place", 32'(place), 32'd0);
        chk("t6_rst_pos", 32'(mouse_pos), 32'd0);
        chk("t6_rst_cell", 32'(cell_idx), 32'd127);
        chk("t6_rst_left", 32'(ships_left), 32'd4);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        press_start();
        p0 = n_place;
        click_rc(0, 1);
        chk("t6_map_cleared", 32'(n_place - p0), 32'd1);
        chk("t6_left_after", 32'(ships_left), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
